c7bifu_fpipe: RTL
=================

// Module: c7bifu_fpipe
// PURPOSE
//  Parametrised fetch pipe: next-generation PC generator plus instruction queue for c7bifu.
//  Issues block-aligned fetch requests to the ICU with up to MAX_OUTST requests in flight.
//  Slices FETCH_INSTS-wide response beats into a DEPTH-entry queue and presents one
//  instruction per cycle to c7bifu_dec. On a redirect it flushes the queue and drops
//  stale in-flight responses.
// PARAMETERS
//  RESET_PC     32'h1c000000  fetch address after reset
//  FETCH_INSTS  2             32-bit instructions per ICU beat; power of 2, 1..4
//  MAX_OUTST    2             max acked requests awaiting data; 1..4
//  IQ_DEPTH     8             queue entries; power of 2, >= FETCH_INSTS*MAX_OUTST
// PORTS
//  clk                     in   1               clock
//  resetn                  in   1               synchronous reset, active low
//  ifu_icu_addr_ic1        out  32              fetch address (block aligned + offset, see below)
//  ifu_icu_req_ic1         out  1               fetch request
//  icu_ifu_ack_ic1         in   1               request accepted this cycle
//  icu_ifu_data_valid_ic2  in   1               response beat valid (in order)
//  icu_ifu_data_ic2        in   32*FETCH_INSTS  beat; slot i = bits [32i+31:32i], i=0 lowest addr
//  exu_ifu_except          in   1               redirect to exu_ifu_isr_addr
//  exu_ifu_isr_addr        in   32              exception target
//  exu_ifu_ertn            in   1               redirect to exu_ifu_ert_addr
//  exu_ifu_ert_addr        in   32              ertn target
//  exu_ifu_branch          in   1               redirect to exu_ifu_brn_addr
//  exu_ifu_brn_addr        in   32              branch target
//  exu_ifu_stall           in   1               decode stall; blocks pop
//  inst_vld_f              out  1               queue head valid
//  inst_f                  out  32              head instruction
//  inst_addr_f             out  32              head PC
// BEHAVIOUR
//  Reset (resetn=0 at posedge):
//   - req=0, inst_vld_f=0, all counters 0, fetch PC = RESET_PC; addr_ic1 drives RESET_PC.
//   - First req is asserted the cycle after reset deasserts.
//   - Reset mid-operation discards everything; late data_valid beats after reset are ignored.
//  Redirect:
//   - Priority except > ertn > branch; flush = any of the three.
//   - Flush cycle: queue emptied, inst_vld_f=0; target becomes fetch PC.
//   - drop_cnt += outstanding count; outstanding cleared.
//   - A data beat in the flush cycle is dropped. A request acked in the flush cycle is
//     not counted (it carried the old address) unless addr_ic1 already showed the target.
//   - Rule: addr_ic1 shows the target combinationally in the flush cycle, so an ack in
//     that cycle accepts the target and counts as outstanding.
//  Request / handshake:
//   - req = !flush_pending_reset && outst+drop < MAX_OUTST &&
//     free >= FETCH_INSTS, where free = IQ_DEPTH - count - outst*FETCH_INSTS.
//   - Req/addr are held until ack. Addr may change before ack only due to flush.
//   - On ack: outst+1; PC = block_base(PC) + FETCH_INSTS*4 (32-bit wrap, no flag).
//     The first-slot offset of the acked request is pushed to a MAX_OUTST-deep tag FIFO.
//  Response:
//   - data_valid with drop_cnt>0: drop_cnt-1, beat discarded.
//   - Otherwise outst-1 and slots [off..FETCH_INSTS-1] are pushed with PC =
//     base+4*slot. off comes from the tag FIFO: nonzero only for a mid-block redirect
//     target, else 0.
//   - data_valid with outst=0 and drop_cnt=0 is ignored.
//   - Data latency >= 1 cycle after ack; same-cycle ack+data allowed for different requests.
//  Queue:
//   - inst_vld_f = count!=0; pop when inst_vld_f && !exu_ifu_stall.
//   - Push and pop in the same cycle are both honoured. The reservation rule guarantees
//     no overflow; the full queue blocks req only.
//   - Pointers wrap modulo IQ_DEPTH.
// CONFIGURATION
//  C7BIFU_FPIPE_PERF_EN defined: adds 32-bit outputs perf_bubble_cnt and perf_redirect_cnt.
//   - perf_bubble_cnt: +1 per cycle with !inst_vld_f && !exu_ifu_stall.
//   - perf_redirect_cnt: +1 per flush cycle.
//   - Both reset to 0 and wrap at 2^32.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Reset release, ack every req, data 2 cycles later, stall=0 ->
//     inst_addr_f 1c000000, 1c000004, 1c000008 ... contiguous, no gaps once the pipe fills.
//  2. exu_ifu_stall=1 for 20 cycles (defaults) ->
//     req drops after 8 insts are queued/reserved; no beat lost; order intact after release.
//  3. Branch to 1c000104 with 2 requests outstanding ->
//     both late beats dropped; first inst_addr_f=1c000104 (slot 0 skipped), then 1c000108.
//  4. except + branch same cycle (isr 1c001000, brn 1c000200) ->
//     fetch resumes at 1c001000; perf_redirect_cnt +1 with PERF_EN.
//  5. FETCH_INSTS=4, IQ_DEPTH=16, MAX_OUTST=4, PC near ffffffe0 ->
//     addresses wrap to 00000000; 4 insts per beat are queued in slot order.
//  6. Assert resetn=0 while 2 are outstanding, then send 2 data beats ->
//     beats ignored, inst_vld_f=0, new fetch at 1c000000.

Source files
------------

// File: rtl/c7bifu_fpipe.sv
// c7bifu fetch pipe: PC generator, ICU request tracking and instruction queue.
// Define C7BIFU_FPIPE_PERF_EN to add the perf_bubble_cnt / perf_redirect_cnt outputs.
module c7bifu_fpipe #(
    parameter logic [31:0] RESET_PC    = 32'h1c000000,
    parameter int          FETCH_INSTS = 2,
    parameter int          MAX_OUTST   = 2,
    parameter int          IQ_DEPTH    = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    output logic [31:0]               ifu_icu_addr_ic1,
    output logic                      ifu_icu_req_ic1,
    input  logic                      icu_ifu_ack_ic1,
    input  logic                      icu_ifu_data_valid_ic2,
    input  logic [32*FETCH_INSTS-1:0] icu_ifu_data_ic2,
    input  logic                      exu_ifu_except,
    input  logic [31:0]               exu_ifu_isr_addr,
    input  logic                      exu_ifu_ertn,
    input  logic [31:0]               exu_ifu_ert_addr,
    input  logic                      exu_ifu_branch,
    input  logic [31:0]               exu_ifu_brn_addr,
    input  logic                      exu_ifu_stall,
    output logic                      inst_vld_f,
    output logic [31:0]               inst_f,
    output logic [31:0]               inst_addr_f
`ifdef C7BIFU_FPIPE_PERF_EN
    ,
    output logic [31:0]               perf_bubble_cnt,
    output logic [31:0]               perf_redirect_cnt
`endif
);
    localparam int OFF_W = (FETCH_INSTS > 1) ? $clog2(FETCH_INSTS) : 1;
    localparam int PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(IQ_DEPTH + 1);
    localparam int TAG_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [31:0] BLK_BYTES = 32'(FETCH_INSTS * 4);
    localparam logic [31:0] BLK_MASK  = ~(BLK_BYTES - 32'd1);

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_base;
    logic             reset_pending;
    logic [2:0]       outst;
    logic [2:0]       drop_cnt;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      iq_inst [IQ_DEPTH];
    logic [31:0]      iq_pc   [IQ_DEPTH];
    logic [OFF_W-1:0] tag_mem [MAX_OUTST];
    logic [TAG_W-1:0] tag_rd;
    logic [TAG_W-1:0] tag_wr;

    logic             flush;
    logic [31:0]      target;
    logic [31:0]      iq_used;
    logic             accept;
    logic             beat_drop;
    logic             beat_live;
    logic             pop;
    logic [OFF_W-1:0] req_off;
    logic [OFF_W-1:0] beat_off;
    logic [CNT_W-1:0] push_n;

    function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] p);
        return (int'(p) == MAX_OUTST - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        flush = exu_ifu_except | exu_ifu_ertn | exu_ifu_branch;
        if (exu_ifu_except)
            target = exu_ifu_isr_addr;
        else if (exu_ifu_ertn)
            target = exu_ifu_ert_addr;
        else
            target = exu_ifu_brn_addr;
        // The redirect target is visible to the ICU in the flush cycle itself.
        ifu_icu_addr_ic1 = flush ? target : fetch_pc;

        // Queue space is reserved for every accepted request still awaiting data.
        iq_used = 32'(count) + 32'(outst) * 32'(FETCH_INSTS);
        ifu_icu_req_ic1 = !reset_pending
                        && ((32'(outst) + 32'(drop_cnt)) < 32'(MAX_OUTST))
                        && ((iq_used + 32'(FETCH_INSTS)) <= 32'(IQ_DEPTH));
        accept  = ifu_icu_req_ic1 & icu_ifu_ack_ic1;
        req_off = OFF_W'(ifu_icu_addr_ic1[31:2]) & OFF_W'(FETCH_INSTS - 1);

        beat_drop = icu_ifu_data_valid_ic2 && (drop_cnt != 3'd0);
        beat_live = icu_ifu_data_valid_ic2 && (drop_cnt == 3'd0) && (outst != 3'd0);
        beat_off  = tag_mem[tag_rd];
        push_n    = (beat_live && !flush) ? CNT_W'(FETCH_INSTS) - CNT_W'(beat_off) : '0;

        inst_vld_f  = (count != '0) && !flush;
        pop         = inst_vld_f && !exu_ifu_stall;
        inst_f      = iq_inst[rd_ptr];
        inst_addr_f = iq_pc[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc      <= RESET_PC;
            resp_base     <= RESET_PC & BLK_MASK;
            reset_pending <= 1'b1;
            outst         <= 3'd0;
            drop_cnt      <= 3'd0;
            count         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            tag_rd        <= '0;
            tag_wr        <= '0;
        end else begin
            reset_pending <= 1'b0;
            if (accept)
                fetch_pc <= (ifu_icu_addr_ic1 & BLK_MASK) + BLK_BYTES;
            else if (flush)
                fetch_pc <= target;

            if (flush) begin
                // Everything in flight becomes stale; a same-cycle ack carried the target.
                drop_cnt  <= drop_cnt + outst - {2'b00, beat_drop | beat_live};
                outst     <= {2'b00, accept};
                count     <= '0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                resp_base <= target & BLK_MASK;
                tag_rd    <= '0;
                tag_wr    <= accept ? tag_inc('0) : '0;
            end else begin
                drop_cnt <= drop_cnt - {2'b00, beat_drop};
                outst    <= outst + {2'b00, accept} - {2'b00, beat_live};
                count    <= count + push_n - CNT_W'(pop);
                rd_ptr   <= rd_ptr + PTR_W'(pop);
                wr_ptr   <= wr_ptr + PTR_W'(push_n);
                if (beat_live) begin
                    resp_base <= resp_base + BLK_BYTES;
                    tag_rd    <= tag_inc(tag_rd);
                end
                if (accept)
                    tag_wr <= tag_inc(tag_wr);
            end
        end
    end

    // Storage arrays need no reset; occupancy is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        for (int s = 0; s < FETCH_INSTS; s++) begin
            if (resetn && beat_live && !flush && (s >= int'(beat_off))) begin
                iq_inst[wr_ptr + PTR_W'(s - int'(beat_off))] <= icu_ifu_data_ic2[32*s +: 32];
                iq_pc[wr_ptr + PTR_W'(s - int'(beat_off))]   <= resp_base + 32'(4 * s);
            end
        end
        if (resetn && accept)
            tag_mem[flush ? '0 : tag_wr] <= req_off;
    end

`ifdef C7BIFU_FPIPE_PERF_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_bubble_cnt   <= 32'd0;
            perf_redirect_cnt <= 32'd0;
        end else begin
            if (!inst_vld_f && !exu_ifu_stall)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (flush)
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
        end
    end
`else
    // Build without performance counters.
`endif

endmodule
